// File: rtl/jf_pkg.sv
// Shared constants and types for the Jack-Frost hit-detection logic.
//   Sprite sizes (pixels), coordinate widths, and the width used for all
//   zero-extended coordinate sums so that no comparison can wrap.
package jf_pkg;

    // Coordinate widths
    localparam int unsigned X_W   = 10;
    localparam int unsigned Y_W   = 9;
    // All coordinate sums are evaluated at this width
    localparam int unsigned SUM_W = 11;
    localparam int unsigned ADDR_W = 19;

    // Sprite sizes
    localparam int unsigned BLUE_W = 47;
    localparam int unsigned BLUE_H = 41;
    localparam int unsigned SLIM_W = 62;
    localparam int unsigned SLIM_H = 36;
    localparam int unsigned GND_W  = 28;
    localparam int unsigned GND_H  = 42;
    localparam int unsigned BG_W   = 551;
    localparam int unsigned BG_H   = 401;

    typedef logic [X_W-1:0]   x_t;
    typedef logic [Y_W-1:0]   y_t;
    typedef logic [SUM_W-1:0] sum_t;

    function automatic sum_t ext_x(x_t v);
        return sum_t'(v);
    endfunction

    function automatic sum_t ext_y(y_t v);
        return sum_t'(v);
    endfunction

endpackage

// File: rtl/jf_box_overlap.sv
// Combinational axis-aligned bounding-box overlap test.
//   a_x_i/a_y_i : top-left of box A (AW x AH)
//   b_x_i/b_y_i : top-left of box B (BW x BH)
//   hit_o       : boxes share at least one pixel
module jf_box_overlap
    import jf_pkg::*;
#(
    parameter int unsigned AW = 1,
    parameter int unsigned AH = 1,
    parameter int unsigned BW = 1,
    parameter int unsigned BH = 1
) (
    input  logic [X_W-1:0] a_x_i,
    input  logic [Y_W-1:0] a_y_i,
    input  logic [X_W-1:0] b_x_i,
    input  logic [Y_W-1:0] b_y_i,
    output logic           hit_o
);

    sum_t ax, ay, bx, by;
    logic x_hit, y_hit;

    assign ax = ext_x(a_x_i);
    assign ay = ext_y(a_y_i);
    assign bx = ext_x(b_x_i);
    assign by = ext_y(b_y_i);

    assign x_hit = (ax <= bx + sum_t'(BW - 1)) && (ax + sum_t'(AW - 1) >= bx);
    assign y_hit = (ay <= by + sum_t'(BH - 1)) && (ay + sum_t'(AH - 1) >= by);
    assign hit_o = x_hit && y_hit;

endmodule

// File: rtl/jf_hit_detect.sv
// Jack-Frost game-logic detection core.
//   Inputs : player position, packed ground-block and monster positions,
//            monster frozen flags, VGA scan column/row.
//   Outputs: touched    - sticky per-block "iced" flags
//            broken     - player overlaps unfrozen monster i (not sticky)
//            health     - remaining health, invincible window flag, dead
//            bg_addr    - background ROM address for the scan position
//   All outputs are registered; clk/rst are synchronous, rst active-high.
module jf_hit_detect
    import jf_pkg::*;
#(
    parameter int unsigned NG            = 50,
    parameter int unsigned NM            = 2,
    parameter int unsigned HEALTH_INIT   = 3,
    parameter int unsigned INVULN_CYCLES = 300_000_000,
    parameter int unsigned FEET_TOL      = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [X_W-1:0]      x_blue,
    input  logic [Y_W-1:0]      y_blue,
    input  logic [NG*X_W-1:0]   x_ground,
    input  logic [NG*Y_W-1:0]   y_ground,
    input  logic [NM*X_W-1:0]   x_slim,
    input  logic [NM*Y_W-1:0]   y_slim,
    input  logic [NM-1:0]       slim_frozen,
    input  logic [X_W-1:0]      col_addr,
    input  logic [Y_W-1:0]      row_addr,
    output logic [NG-1:0]       touched,
    output logic [NM-1:0]       broken,
    output logic [3:0]          health,
    output logic                invincible,
    output logic                dead,
    output logic [ADDR_W-1:0]   bg_addr
);

    // Counter holds INVULN_CYCLES-1 down to 0
    localparam int unsigned CntW = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;

    logic [NG-1:0]     touched_d, touched_q;
    logic [NM-1:0]     broken_d, broken_q;
    logic [3:0]        health_d, health_q;
    logic              inv_d, inv_q;
    logic              dead_d, dead_q;
    logic [CntW-1:0]   cnt_d, cnt_q;
    logic [ADDR_W-1:0] bg_addr_d, bg_addr_q;
    logic [NM-1:0]     slim_hit;

    sum_t bx, feet;
    assign bx   = ext_x(x_blue);
    assign feet = ext_y(y_blue) + sum_t'(BLUE_H);

    // Block landing: horizontal overlap and feet within FEET_TOL below block top
    always_comb begin
        touched_d = touched_q;
        for (int i = 0; i < NG; i++) begin
            if ((bx <= ext_x(x_ground[i*X_W +: X_W]) + sum_t'(GND_W - 1)) &&
                (bx + sum_t'(BLUE_W - 1) >= ext_x(x_ground[i*X_W +: X_W])) &&
                (ext_y(y_ground[i*Y_W +: Y_W]) <= feet) &&
                (feet <= ext_y(y_ground[i*Y_W +: Y_W]) + sum_t'(FEET_TOL))) begin
                touched_d[i] = 1'b1;
            end
        end
    end

    for (genvar m = 0; m < NM; m++) begin : g_slim
        jf_box_overlap #(
            .AW (BLUE_W),
            .AH (BLUE_H),
            .BW (SLIM_W),
            .BH (SLIM_H)
        ) u_overlap (
            .a_x_i (x_blue),
            .a_y_i (y_blue),
            .b_x_i (x_slim[m*X_W +: X_W]),
            .b_y_i (y_slim[m*Y_W +: Y_W]),
            .hit_o (slim_hit[m])
        );
    end

    assign broken_d = slim_hit & ~slim_frozen;

    // Health uses the registered broken flags, so a hit costs health one edge
    // after broken rises. Any number of simultaneous hits costs one point.
    always_comb begin
        health_d = health_q;
        inv_d    = inv_q;
        cnt_d    = cnt_q;
        if (inv_q) begin
            if (cnt_q == '0) begin
                inv_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (|broken_q) begin
            health_d = (health_q == 4'd0) ? 4'd0 : health_q - 4'd1;
            inv_d    = 1'b1;
            cnt_d    = CntW'(INVULN_CYCLES - 1);
        end
        dead_d = (health_d == 4'd0);
    end

    // Background ROM address; out-of-picture scan positions read address 0
    always_comb begin
        bg_addr_d = '0;
        if ((col_addr <= X_W'(BG_W - 1)) && (row_addr <= Y_W'(BG_H - 1))) begin
            bg_addr_d = ADDR_W'(row_addr) * ADDR_W'(BG_W) + ADDR_W'(col_addr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            touched_q <= '0;
            broken_q  <= '0;
            health_q  <= 4'(HEALTH_INIT);
            inv_q     <= 1'b0;
            dead_q    <= (HEALTH_INIT == 0);
            cnt_q     <= '0;
            bg_addr_q <= '0;
        end else begin
            touched_q <= touched_d;
            broken_q  <= broken_d;
            health_q  <= health_d;
            inv_q     <= inv_d;
            dead_q    <= dead_d;
            cnt_q     <= cnt_d;
            bg_addr_q <= bg_addr_d;
        end
    end

    assign touched    = touched_q;
    assign broken     = broken_q;
    assign health     = health_q;
    assign invincible = inv_q;
    assign dead       = dead_q;
    assign bg_addr    = bg_addr_q;

endmodule

// File: tb/tb_jf_hit_detect.sv
// Scoreboard bench for jf_hit_detect: stimulus pushes expected output values
// tagged with the cycle they are due; a monitor compares them on negedges.
module tb_jf_hit_detect;

    localparam int unsigned NG = 4;
    localparam int unsigned NM = 2;

    typedef enum int {KTouch, KBroken, KHealth, KInv, KDead, KBg} kind_e;
    typedef struct {
        int          due;
        kind_e       kind;
        logic [63:0] val;
        string       name;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [9:0]        x_blue;
    logic [8:0]        y_blue;
    logic [NG*10-1:0]  x_ground;
    logic [NG*9-1:0]   y_ground;
    logic [NM*10-1:0]  x_slim;
    logic [NM*9-1:0]   y_slim;
    logic [NM-1:0]     slim_frozen;
    logic [9:0]        col_addr;
    logic [8:0]        row_addr;
    logic [NG-1:0]     touched;
    logic [NM-1:0]     broken;
    logic [3:0]        health;
    logic              invincible;
    logic              dead;
    logic [18:0]       bg_addr;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    jf_hit_detect #(
        .NG            (NG),
        .NM            (NM),
        .HEALTH_INIT   (3),
        .INVULN_CYCLES (10),
        .FEET_TOL      (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .x_blue      (x_blue),
        .y_blue      (y_blue),
        .x_ground    (x_ground),
        .y_ground    (y_ground),
        .x_slim      (x_slim),
        .y_slim      (y_slim),
        .slim_frozen (slim_frozen),
        .col_addr    (col_addr),
        .row_addr    (row_addr),
        .touched     (touched),
        .broken      (broken),
        .health      (health),
        .invincible  (invincible),
        .dead        (dead),
        .bg_addr     (bg_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] actual(kind_e k);
        case (k)
            KTouch:  return 64'(touched);
            KBroken: return 64'(broken);
            KHealth: return 64'(health);
            KInv:    return 64'(invincible);
            KDead:   return 64'(dead);
            default: return 64'(bg_addr);
        endcase
    endfunction

    // Monitor: compare every expectation due at this cycle
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                checks++;
                if (actual(sb[i].kind) !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s @cyc %0d: got %0d, expected %0d", sb[i].name, cyc,
                             actual(sb[i].kind), sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(int dly, kind_e k, logic [63:0] v, string name);
        exp_t e;
        e.due  = cyc + dly;
        e.kind = k;
        e.val  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic set_block(int i, int x, int y);
        x_ground[i*10 +: 10] = 10'(x);
        y_ground[i*9 +: 9]   = 9'(y);
    endtask

    task automatic set_slim(int i, int x, int y);
        x_slim[i*10 +: 10] = 10'(x);
        y_slim[i*9 +: 9]   = 9'(y);
    endtask

    task automatic expect_reset_state(string tag);
        expect_at(1, KTouch,  0, {tag, "_touched"});
        expect_at(1, KBroken, 0, {tag, "_broken"});
        expect_at(1, KHealth, 3, {tag, "_health"});
        expect_at(1, KInv,    0, {tag, "_invincible"});
        expect_at(1, KDead,   0, {tag, "_dead"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        x_blue      = 10'd300;
        y_blue      = 9'd0;
        x_ground    = '0;
        y_ground    = '0;
        x_slim      = '0;
        y_slim      = '0;
        slim_frozen = '0;
        col_addr    = '0;
        row_addr    = '0;
        set_block(0, 28, 374);
        set_block(1, 200, 100);
        set_block(2, 600, 100);
        set_block(3, 900, 500);
        set_slim(0, 900, 500);
        set_slim(1, 900, 500);

        // Reset state
        tick();
        expect_reset_state("reset");
        expect_at(1, KBg, 0, "reset_bg");
        tick();
        rst = 1'b0;

        // Feet at 371, above block0: no landing
        x_blue = 10'd20; y_blue = 9'd330;
        expect_at(1, KTouch, 0, "land_above");
        tick();
        // Feet at 374 on block0
        y_blue = 9'd333;
        expect_at(1, KTouch, 4'b0001, "land_block0");
        tick();
        // Moving away keeps the flag
        x_blue = 10'd300; y_blue = 9'd0;
        expect_at(1, KTouch, 4'b0001, "land_sticky");
        tick();
        // Feet at 103 = block top + FEET_TOL on block1
        x_blue = 10'd200; y_blue = 9'd62;
        expect_at(1, KTouch, 4'b0011, "land_tol_edge");
        tick();
        // Feet at 104, one past tolerance on block2
        x_blue = 10'd600; y_blue = 9'd63;
        expect_at(1, KTouch, 4'b0011, "land_tol_past");
        expect_at(1, KHealth, 3, "land_health");
        tick();

        // Background address
        col_addr = 10'd0;   row_addr = 9'd0;   expect_at(1, KBg, 0, "bg_0_0");        tick();
        col_addr = 10'd550; row_addr = 9'd400; expect_at(1, KBg, 220950, "bg_max"); tick();
        col_addr = 10'd551; row_addr = 9'd0;   expect_at(1, KBg, 0, "bg_col_out");    tick();
        col_addr = 10'd10;  row_addr = 9'd2;   expect_at(1, KBg, 1112, "bg_10_2");   tick();
        col_addr = 10'd550; row_addr = 9'd401; expect_at(1, KBg, 0, "bg_row_out");    tick();

        // Frozen monster is harmless
        x_blue = 10'd60; y_blue = 9'd10;
        set_slim(0, 48, 0);
        slim_frozen = 2'b11;
        expect_at(1, KBroken, 0, "frozen_broken_a");
        expect_at(2, KBroken, 0, "frozen_broken_b");
        expect_at(3, KHealth, 3, "frozen_health");
        expect_at(3, KInv,    0, "frozen_inv");
        ticks(3);

        // Unfreeze with continuous overlap, INVULN_CYCLES = 10
        slim_frozen = 2'b00;
        expect_at(1,  KBroken, 2'b01, "hit_broken");
        expect_at(1,  KHealth, 3, "hit_health_pre");
        expect_at(2,  KHealth, 2, "hit_health_2");
        expect_at(2,  KInv,    1, "hit_inv_on");
        expect_at(11, KInv,    1, "win_inv_last");
        expect_at(12, KInv,    0, "win_inv_clear");
        expect_at(12, KHealth, 2, "win_health_hold");
        expect_at(13, KHealth, 1, "win_health_1");
        expect_at(13, KInv,    1, "win2_inv_on");
        expect_at(23, KInv,    0, "win2_inv_clear");
        expect_at(24, KHealth, 0, "sat_health_0");
        expect_at(24, KDead,   1, "sat_dead");
        expect_at(35, KHealth, 0, "sat_health_hold");
        expect_at(35, KDead,   1, "sat_dead_hold");
        expect_at(35, KInv,    1, "sat_inv_on");
        ticks(36);

        // Reset mid-invincibility with touched bits set
        expect_at(0, KInv, 1, "pre_reset_inv");
        expect_at(0, KTouch, 4'b0011, "pre_reset_touched");
        rst = 1'b1;
        expect_reset_state("midrst");
        tick();

        // Two monsters hit at once cost one health
        rst = 1'b0;
        set_slim(1, 50, 5);
        expect_at(1, KBroken, 2'b11, "dual_broken");
        expect_at(2, KHealth, 2, "dual_health");
        expect_at(2, KInv,    1, "dual_inv");
        expect_at(2, KTouch,  0, "dual_touched");
        expect_at(4, KHealth, 2, "dual_health_hold");
        ticks(4);

        // Broken is not sticky
        x_blue = 10'd300; y_blue = 9'd300;
        expect_at(1, KBroken, 0, "broken_clear");
        ticks(3);

        checks++;
        if (touched !== 4'b0000) begin
            errors++;
            $display("FAIL final_touched: got %0d, expected 0", touched);
        end
        checks++;
        if (broken !== 2'b00) begin
            errors++;
            $display("FAIL final_broken: got %0d, expected 0", broken);
        end
        checks++;
        if (health !== 4'd2) begin
            errors++;
            $display("FAIL final_health: got %0d, expected 2", health);
        end
        checks++;
        if (invincible !== 1'b1 || dead !== 1'b0) begin
            errors++;
            $display("FAIL final_inv_dead: got inv=%0d dead=%0d, expected inv=1 dead=0",
                     invincible, dead);
        end
        checks++;
        if (bg_addr !== 19'd0) begin
            errors++;
            $display("FAIL final_bg: got %0d, expected 0", bg_addr);
        end

        for (int i = 0; i < sb.size(); i++) begin
            errors++;
            $display("FAIL %s: got no comparison, expected %0d", sb[i].name, sb[i].val);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
